// File: rtl/iiitb_fetch_unit.sv
// Instruction-fetch front end: PC generation, 1-cycle imem requests, prefetch FIFO, decode handshake.
// Define FETCH_STATS_EN to add the stat_fetched / stat_flushed counters.
module iiitb_fetch_unit #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       stat_fetched,
   output logic [31:0]       stat_flushed
`endif
);

   localparam int unsigned       PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       CNT_W      = PTR_W + 1;
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
   localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] tag;
   logic              inflight;
   logic              kill;

   logic [31:0]       fifo_instr [DEPTH];
   logic [ADDR_W-1:0] fifo_pc    [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [CNT_W-1:0]  occupancy;
   logic              push;
   logic              pop;

   // Occupancy counts the in-flight slot so a returning response always has room.
   always_comb begin
      occupancy = count + CNT_W'(inflight);
      push      = inflight && !kill;
      pop       = if_valid && if_ready;
      imem_req  = reset && !redirect_valid && (occupancy < DEPTH_CNT);
      imem_addr = fetch_pc;
   end

   always_comb begin
      if_valid = (count != '0);
      if_instr = '0;
      if_pc    = '0;
      if (if_valid) begin
         if_instr = fifo_instr[rd_ptr];
         if_pc    = fifo_pc[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_ADDR;
         tag      <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
      end else begin
         inflight <= imem_req;
         kill     <= redirect_valid && inflight;
         if (imem_req) begin
            tag <= fetch_pc;
         end
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
         end else if (imem_req) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
         end
      end
   end

   // A redirect flushes everything, including a response being pushed in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redirect_valid) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= tag;
      end
   end

`ifdef FETCH_STATS_EN
   // Entries handed to decode in the redirect cycle are consumed, not flushed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
      end else begin
         if (pop) begin
            stat_fetched <= stat_fetched + 32'd1;
         end
         if (redirect_valid) begin
            stat_flushed <= stat_flushed + 32'(count) - 32'(pop) + 32'(push);
         end
      end
   end
`endif

   assert property (@(posedge clk) disable iff (!reset) occupancy <= DEPTH_CNT);

endmodule

// File: tb/tb_iiitb_fetch_unit.sv
// Self-checking bench for iiitb_fetch_unit: queue-based delivery model plus directed literal checks.
module tb_iiitb_fetch_unit;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned NWORDS = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata = 32'hDEAD_BEEF;
   logic              if_valid;
   logic              if_ready;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
`ifdef FETCH_STATS_EN
   logic [31:0]       stat_fetched;
   logic [31:0]       stat_flushed;
`endif

   iiitb_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_flushed   (stat_flushed)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous memory: word i holds 0x100+i, data returns the cycle after the request.
   always @(posedge clk) begin
      if (imem_req === 1'b1) imem_rdata <= 32'h100 + 32'(imem_addr);
      else                   imem_rdata <= 32'hDEAD_BEEF;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of PCs ready for decode, one pending request, next fetch address.
   int          mq[$];
   int          m_next = 0;
   int          m_pend = -1;
   int unsigned m_fetched = 0;
   int unsigned m_flushed = 0;
   int          got[$];

   function automatic bit exp_req();
      int occ;
      occ = mq.size() + ((m_pend >= 0) ? 1 : 0);
      return (reset === 1'b1) && (redirect_valid === 1'b0) && (occ < int'(DEPTH));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_next    = 0;
         m_pend    = -1;
         m_fetched = 0;
         m_flushed = 0;
      end else begin
         bit req;
         bit pop;
         req = exp_req();
         pop = (mq.size() > 0) && (if_ready === 1'b1);
         if (pop) m_fetched++;
         if (redirect_valid === 1'b1) begin
            m_flushed += int'(mq.size()) - (pop ? 1 : 0) + ((m_pend >= 0) ? 1 : 0);
            mq.delete();
            m_next = int'(redirect_pc);
            m_pend = -1;
         end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend >= 0) mq.push_back(m_pend);
            if (req) begin
               m_pend = m_next;
               m_next = (m_next + 1) % NWORDS;
            end else begin
               m_pend = -1;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit er;
      int hpc;
      er  = exp_req();
      hpc = (mq.size() > 0) ? mq[0] : 0;
      check("imem_req", 32'(imem_req), 32'(er));
      if (er) check("imem_addr", 32'(imem_addr), 32'(m_next));
      check("if_valid", 32'(if_valid), 32'(mq.size() > 0));
      check("if_pc", 32'(if_pc), 32'(hpc));
      check("if_instr", if_instr, (mq.size() > 0) ? 32'h100 + 32'(hpc) : 32'h0);
`ifdef FETCH_STATS_EN
      check("stat_fetched", stat_fetched, m_fetched);
      check("stat_flushed", stat_flushed, m_flushed);
`endif
      if (if_valid === 1'b1 && if_ready === 1'b1) got.push_back(int'(if_pc));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_list(input string name, input int exp[$]);
      check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[i]) begin
         if (i < got.size()) check(name, 32'(got[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      logic [15:0] ready_pat;
      ready_pat      = 16'b1011_0010_1110_0101;
      reset          = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(if_valid), 32'h0);
      check("rst_instr", if_instr, 32'h0);

      // Reset release, streaming with decode always ready
      tick();
      reset = 1'b1; if_ready = 1'b1; got.delete();
      @(negedge clk);
      check("first_req", 32'(imem_req), 32'h1);
      check("first_addr", 32'(imem_addr), 32'h0);
      check("c0_valid", 32'(if_valid), 32'h0);
      tick(); @(negedge clk);
      check("c1_valid", 32'(if_valid), 32'h0);
      tick(); @(negedge clk);
      check("c2_valid", 32'(if_valid), 32'h1);
      check("c2_pc", 32'(if_pc), 32'h0);
      check("c2_instr", if_instr, 32'h100);
      repeat (6) tick();
      check_list("stream", '{0, 1, 2, 3, 4, 5});

      // Mid-operation reset, then backpressure fills the FIFO
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1; if_ready = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("full_req", 32'(imem_req), 32'h0);
      check("full_valid", 32'(if_valid), 32'h1);
      check("full_pc", 32'(if_pc), 32'h0);
      check("full_instr", if_instr, 32'h100);
      tick();
      if_ready = 1'b1; got.delete();
      repeat (5) tick();
      check_list("drain", '{0, 1, 2, 3, 4});

      // Redirect with three buffered entries and one in flight
      reset = 1'b0;
      tick();
      reset = 1'b1; if_ready = 1'b0;
      repeat (4) tick();
      redirect_valid = 1'b1; redirect_pc = 5'd22;
      @(negedge clk);
      check("redir_pre_valid", 32'(if_valid), 32'h1);
      check("redir_noreq", 32'(imem_req), 32'h0);
      tick();
      redirect_valid = 1'b0; if_ready = 1'b1; got.delete();
      @(negedge clk);
      check("redir_n1_req", 32'(imem_req), 32'h1);
      check("redir_n1_addr", 32'(imem_addr), 32'd22);
      check("redir_n1_valid", 32'(if_valid), 32'h0);
      tick(); @(negedge clk);
      check("redir_n2_valid", 32'(if_valid), 32'h0);
      tick(); @(negedge clk);
      check("redir_n3_valid", 32'(if_valid), 32'h1);
      check("redir_n3_pc", 32'(if_pc), 32'd22);
      check("redir_n3_instr", if_instr, 32'h116);
      repeat (3) tick();
      check_list("redir", '{22, 23, 24});

      // Back-to-back redirects: last target wins
      redirect_valid = 1'b1; redirect_pc = 5'd10;
      tick();
      redirect_pc = 5'd20; got.delete();
      tick();
      redirect_valid = 1'b0;
      repeat (5) tick();
      check_list("b2b", '{20, 21, 22});

      // Address wrap 31 -> 0
      redirect_valid = 1'b1; redirect_pc = 5'd28;
      tick();
      redirect_valid = 1'b0; got.delete();
      repeat (8) tick();
      check_list("wrap", '{28, 29, 30, 31, 0, 1});

      // Irregular decode backpressure, checked cycle by cycle against the model
      for (int unsigned i = 0; i < 16; i++) begin
         if_ready = ready_pat[i];
         tick();
      end

      // Counters: 5 delivered, then redirect with 2 buffered + 1 in flight
      reset = 1'b0;
      tick();
      reset = 1'b1; if_ready = 1'b1;
      repeat (7) tick();
      if_ready = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_pc = 5'd0;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
      @(negedge clk);
      check("stat_fetched_lit", stat_fetched, 32'd5);
      check("stat_flushed_lit", stat_flushed, 32'd3);
`endif
      repeat (6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
